// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
//   state_t            : FSM encoding (ARM, RUN, TIMEOUT)
//   DEF_WIDTH          : default high/low counter width
//   DEF_TIMEOUT_CYCLES : default cycles without an edge before timeout
//   DEF_SYNC_STAGES    : default synchronizer depth on the measured input
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_ARM     = 2'd0,
    ST_RUN     = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH          = 28;
  localparam int unsigned DEF_TIMEOUT_CYCLES = (2 ** DEF_WIDTH) - 1;
  localparam int unsigned DEF_SYNC_STAGES    = 2;

endpackage

// File: rtl/period_meter_edge_sync.sv
// Synchronizes an asynchronous square wave into the clk domain and flags
// its edges.
//   clk, rst_n : clock, async active-low reset
//   sig_in     : asynchronous input
//   rise_p     : single-cycle pulse, synchronized input went 0 -> 1
//   fall_p     : single-cycle pulse, synchronized input went 1 -> 0
// The pulses are decoded straight from flops so the top acts on them at the
// next edge, giving an edge-to-action latency of SYNC_STAGES+1 cycles.
module edge_sync
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_p,
  output logic fall_p
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   dly;

  // Synchronizer chain followed by one delay flop for edge comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      dly  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      dly  <= sync[SYNC_STAGES-1];
    end
  end

  assign rise_p = sync[SYNC_STAGES-1] & ~dly;
  assign fall_p = ~sync[SYNC_STAGES-1] & dly;

endmodule

// File: rtl/period_meter.sv
// Measures high time, low time and period of a slow square wave in clk
// cycles, and flags loss of signal.
//   clk, rst_n : clock, async active-low reset
//   sig_in     : measured square wave (asynchronous)
//   clear      : synchronous re-arm (synchronizer contents are kept)
//   high_cnt   : cycles of the last completed high phase
//   low_cnt    : cycles of the last completed low phase
//   period_cnt : high_cnt + low_cnt, updated with meas_valid
//   meas_valid : one-cycle pulse, new period_cnt available
//   locked     : a full period has been measured since arm / recovery
//   timeout    : no edge seen for TIMEOUT_CYCLES cycles
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] high_cnt,
  output logic [WIDTH-1:0] low_cnt,
  output logic [WIDTH:0]   period_cnt,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  state_t           state;
  state_t           next_state;
  logic             rise_p;
  logic             fall_p;
  logic             edge_p;
  logic             to_hit;
  logic [WIDTH-1:0] cnt;
  logic             have_hi;
  logic             have_lo;
  logic             pend;

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise_p (rise_p),
    .fall_p (fall_p)
  );

  assign edge_p = rise_p | fall_p;
  assign to_hit = (cnt == WIDTH'(TIMEOUT_CYCLES));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_ARM;
    else        state <= next_state;
  end

  // Next-state logic; clear overrides any edge in the same cycle
  always_comb begin
    next_state = state;
    unique case (state)
      ST_ARM:     if (edge_p) next_state = ST_RUN;
      ST_RUN:     if (!edge_p && to_hit) next_state = ST_TIMEOUT;
      ST_TIMEOUT: if (edge_p) next_state = ST_RUN;
      default:    next_state = ST_ARM;
    endcase
    if (clear) next_state = ST_ARM;
  end

  // Interval counter, capture registers and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      have_hi    <= 1'b0;
      have_lo    <= 1'b0;
      pend       <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      have_hi    <= 1'b0;
      have_lo    <= 1'b0;
      pend       <= 1'b0;
      high_cnt   <= '0;
      low_cnt    <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;

      // Restart on every edge; otherwise count (saturating) once armed
      if (edge_p)                                cnt <= WIDTH'(1);
      else if (state != ST_ARM && cnt != '1)     cnt <= cnt + WIDTH'(1);

      // Period is summed one cycle after the rising-edge capture of low_cnt
      if (pend) begin
        period_cnt <= {1'b0, high_cnt} + {1'b0, low_cnt};
        meas_valid <= 1'b1;
        locked     <= 1'b1;
        pend       <= 1'b0;
      end

      unique case (state)
        ST_RUN: begin
          if (fall_p) begin
            high_cnt <= cnt;
            have_hi  <= 1'b1;
          end
          if (rise_p) begin
            low_cnt <= cnt;
            have_lo <= 1'b1;
            if (have_hi && (have_lo || rise_p)) pend <= 1'b1;
          end
          if (!edge_p && to_hit) begin
            have_hi <= 1'b0;
            have_lo <= 1'b0;
            locked  <= 1'b0;
            timeout <= 1'b1;
          end
        end
        ST_TIMEOUT: begin
          have_hi <= 1'b0;
          have_lo <= 1'b0;
          if (edge_p) timeout <= 1'b0;
        end
        default: begin
          have_hi <= 1'b0;
          have_lo <= 1'b0;
        end
      endcase
    end
  end

endmodule
